haz_detect_unit: RTL
====================

// Module: haz_detect_unit
// PURPOSE
//  Upstream hazard-classification stage for the hazard-resolver FSM. Tracks in-flight destination regs in a 3-entry
//  scoreboard (EX/MEM/WB) and flags RAW, forwardability, memory-port and branch hazards; one outstanding branch + 2-bit
//  predictor table. Registered outputs drive the resolver's data/str/ctrl/fwrd/crct inputs (ui_in bits 7/6/4/3/2).
// PARAMETERS
//  REG_AW      3   register index width; index 0 hardwired zero, never a hazard
//  PC_IDX_W    2   PC bits indexing predictor table (2**PC_IDX_W 2-bit counters)
// PORTS
//  clk           in   1         clock, all state on rising edge
//  rst           in   1         synchronous active-high reset
//  iss_valid     in   1         instruction presented for issue
//  iss_src1      in   REG_AW    source reg 1 (rs1_en qualifies)
//  iss_rs1_en    in   1         src1 used
//  iss_src2      in   REG_AW    source reg 2
//  iss_rs2_en    in   1         src2 used
//  iss_dst       in   REG_AW    destination reg
//  iss_wr_en     in   1         writes iss_dst
//  iss_is_load   in   1         load (result available end of MEM)
//  iss_is_mem    in   1         load/store, occupies memory port in MEM
//  iss_is_branch in   1         conditional branch
//  iss_pc        in   PC_IDX_W  low PC bits for predictor index
//  stall_i       in   1         resolver pc_freeze; issue not accepted
//  flush_i       in   1         resolver do_flush; issue and EX entry discarded
//  br_res_valid  in   1         pending branch resolves this cycle
//  br_res_taken  in   1         actual direction
//  data_o        out  1         RAW hazard vs in-flight dst
//  fwrd_o        out  1         every matching producer forwardable
//  str_o         out  1         memory port busy (MEM holds mem op)
//  ctrl_o        out  1         unresolved branch outstanding
//  crct_o        out  1         last resolved branch predicted correctly
//  pred_taken_o  out  1         combinational prediction for iss_pc
// BEHAVIOUR
//  - Reset (rst=1 at edge): scoreboard valids 0; data_o,fwrd_o,str_o,ctrl_o=0; crct_o=1; all counters=2'b01 (weak NT);
//    pending branch cleared. Reset mid-operation discards all in-flight state same edge.
//  - Accept = iss_valid & !stall_i & !flush_i. Per edge: S3<=S2, S2<=S1; S1<=accept ? {wr_en&&dst!=0,dst,is_load,is_mem} : bubble.
//    flush_i has priority over stall_i; both insert bubble in S1.
//  - match_k = Sk.v & (rs1_en&src1==Sk.dst | rs2_en&src2==Sk.dst), src!=0, gated by iss_valid.
//  - data_o <= |match_k (1-cycle latency from issue sample; re-evaluated every cycle incl. stalled cycles).
//  - fwrd_o <= data hazard & !(match_1 & S1.ld). Load in EX = load-use, not forwardable; S2 load, S3 any: forwardable.
//    Multiple matches: youngest (S1) governs.
//  - str_o <= iss_valid & S2.mem (next-cycle port conflict). Not gated by stall_i.
//  - Branch FSM IDLE/PEND: IDLE->PEND on accept&is_branch (store idx, pred). PEND->IDLE on br_res_valid.
//    Resolve + new branch accept same edge: stays PEND with new branch's idx/pred. Branch accept while PEND and no
//    resolve: ignored for tracking (resolver holds ctrl freeze). br_res_valid in IDLE: ignored, no update.
//  - ctrl_o <= next state==PEND. crct_o <= (br_res_taken==stored pred) on valid resolve; holds otherwise.
//  - Counter update on resolve: taken ? sat-inc (max 3) : sat-dec (min 0), at stored idx. pred_taken_o = ctr[iss_pc][1];
//    same-cycle read of updated idx returns pre-update value (read-before-write).
// CONFIGURATION
//  HAZ_STATS_EN defined: adds outputs stall_cnt_o[15:0] (+1 per cycle stall_i=1) and mispred_cnt_o[15:0]
//    (+1 per resolve with crct=0); both saturate at 16'hFFFF, reset 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - rst=1 2 cycles -> data/fwrd/str/ctrl=0, crct=1, pred_taken=0 for all iss_pc.
//  - Accept ADD dst=3; next cycle issue src1=3 -> data_o=1,fwrd_o=1 next cycle; src1=0 w/ dst=0 producer -> data_o=0.
//  - Accept LOAD dst=5; next issue src2=5 -> data_o=1,fwrd_o=0; hold stall_i 1 cycle -> load in S2, data_o=1,fwrd_o=1.
//  - Store accepted; 2 cycles later iss_valid=1 -> str_o=1 exactly one cycle; flush_i on an accept -> S1 bubble, no RAW.
//  - Branch pc=2 accepted -> ctrl_o=1; resolve taken -> ctrl_o=0,crct_o=0, ctr[2]=2; repeat -> pred_taken=1, crct_o=1.
//  - Resolve + new branch same cycle -> ctrl_o stays 1; HAZ_STATS_EN: 3 mispredicts -> mispred_cnt_o=3.

Source files
------------

// File: rtl/haz_detect_unit.sv
// Hazard classification ahead of the resolver FSM: an EX/MEM/WB destination scoreboard, a single outstanding branch
// tracker and a 2-bit predictor table. Optional HAZ_STATS_EN adds saturating stall and mispredict counters.
module haz_detect_unit #(
  parameter int REG_AW   = 3,
  parameter int PC_IDX_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic [REG_AW-1:0]   iss_src1,
  input  logic                iss_rs1_en,
  input  logic [REG_AW-1:0]   iss_src2,
  input  logic                iss_rs2_en,
  input  logic [REG_AW-1:0]   iss_dst,
  input  logic                iss_wr_en,
  input  logic                iss_is_load,
  input  logic                iss_is_mem,
  input  logic                iss_is_branch,
  input  logic [PC_IDX_W-1:0] iss_pc,
  input  logic                stall_i,
  input  logic                flush_i,
  input  logic                br_res_valid,
  input  logic                br_res_taken,
  output logic                data_o,
  output logic                fwrd_o,
  output logic                str_o,
  output logic                ctrl_o,
  output logic                crct_o,
  output logic                pred_taken_o
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]         stall_cnt_o,
  output logic [15:0]         mispred_cnt_o
`endif
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;
  localparam int NUM_CTR = 2 ** PC_IDX_W;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] dst;
    logic              ld;
    logic              mem;
  } sb_t;

  // Entry 0 = EX (S1), 1 = MEM (S2), 2 = WB (S3)
  sb_t  sb_reg [3];
  sb_t  sb_next;
  logic [2:0] match;

  logic accept;
  logic br_accept;
  logic resolve;

  logic [0:0]          br_state_reg, br_state_next;
  logic [PC_IDX_W-1:0] br_idx_reg, br_idx_next;
  logic                br_pred_reg, br_pred_next;
  logic [1:0]          ctr_reg [NUM_CTR];

  assign accept    = iss_valid & ~stall_i & ~flush_i;
  assign br_accept = accept & iss_is_branch;
  assign resolve   = (br_state_reg == PEND) & br_res_valid;

  always_comb begin
    sb_next     = '0;
    if (accept) begin
      sb_next.v   = iss_wr_en && (iss_dst != '0);
      sb_next.dst = iss_dst;
      sb_next.ld  = iss_is_load;
      sb_next.mem = iss_is_mem;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_match
      assign match[gi] = iss_valid & sb_reg[gi].v &
                         ((iss_rs1_en & (iss_src1 != '0) & (iss_src1 == sb_reg[gi].dst)) |
                          (iss_rs2_en & (iss_src2 != '0) & (iss_src2 == sb_reg[gi].dst)));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      sb_reg[0] <= '0;
      sb_reg[1] <= '0;
      sb_reg[2] <= '0;
      data_o    <= 1'b0;
      fwrd_o    <= 1'b0;
      str_o     <= 1'b0;
    end else begin
      sb_reg[2] <= sb_reg[1];
      sb_reg[1] <= sb_reg[0];
      sb_reg[0] <= sb_next;
      data_o    <= |match;
      // A load still in EX cannot forward; it overrides any older forwardable match
      fwrd_o    <= (|match) & ~(match[0] & sb_reg[0].ld);
      str_o     <= iss_valid & sb_reg[1].mem;
    end
  end

  // A second branch arriving while one is pending is not tracked unless the pending one resolves this edge
  always_comb begin
    br_state_next = br_state_reg;
    br_idx_next   = br_idx_reg;
    br_pred_next  = br_pred_reg;
    if ((br_state_reg == IDLE) || br_res_valid) begin
      if (br_accept) begin
        br_state_next = PEND;
        br_idx_next   = iss_pc;
        br_pred_next  = ctr_reg[iss_pc][1];
      end else begin
        br_state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_state_reg <= IDLE;
      br_idx_reg   <= '0;
      br_pred_reg  <= 1'b0;
      crct_o       <= 1'b1;
    end else begin
      br_state_reg <= br_state_next;
      br_idx_reg   <= br_idx_next;
      br_pred_reg  <= br_pred_next;
      if (resolve) crct_o <= (br_res_taken == br_pred_reg);
    end
  end

  assign ctrl_o = (br_state_reg == PEND);

  generate
    for (genvar gi = 0; gi < NUM_CTR; gi++) begin : g_ctr
      always_ff @(posedge clk) begin
        if (rst) begin
          ctr_reg[gi] <= 2'b01;
        end else if (resolve && (br_idx_reg == gi[PC_IDX_W-1:0])) begin
          if (br_res_taken) begin
            if (ctr_reg[gi] != 2'b11) ctr_reg[gi] <= ctr_reg[gi] + 2'b01;
          end else begin
            if (ctr_reg[gi] != 2'b00) ctr_reg[gi] <= ctr_reg[gi] - 2'b01;
          end
        end
      end
    end
  endgenerate

  // Reads the registered counter, so a same-edge update is not visible yet
  assign pred_taken_o = ctr_reg[iss_pc][1];

`ifdef HAZ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o   <= '0;
      mispred_cnt_o <= '0;
    end else begin
      if (stall_i && (stall_cnt_o != 16'hFFFF)) stall_cnt_o <= stall_cnt_o + 16'd1;
      if (resolve && (br_res_taken != br_pred_reg) && (mispred_cnt_o != 16'hFFFF))
        mispred_cnt_o <= mispred_cnt_o + 16'd1;
    end
  end
`endif

endmodule
